// File: rtl/acc_requant_if.sv
//------------------------------------------------------------------------------
// acc_requant_if
// Streaming bundle between the conv accumulator, the requantizer and the
// output write DMA.
//   s_sum   : DN signed DW-bit final sums, lane i at [i*DW +: DW]
//   s_valid : beat strobe from the accumulator (no ready is returned)
//   o_data  : DN requantized OW-bit lanes, lane i at [i*OW +: OW]
//   o_valid : requantizer has a beat available
//   o_ready : downstream accepts the current beat
// Modports:
//   master : producer/consumer side (accumulator + DMA, or a testbench)
//   slave  : the requantizer itself
//------------------------------------------------------------------------------
interface acc_requant_if #(
  parameter int DW = 22,
  parameter int DN = 6,
  parameter int OW = 8
);
  logic [DW*DN-1:0] s_sum;
  logic             s_valid;
  logic [OW*DN-1:0] o_data;
  logic             o_valid;
  logic             o_ready;

  modport master (
    output s_sum,
    output s_valid,
    output o_ready,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  s_sum,
    input  s_valid,
    input  o_ready,
    output o_data,
    output o_valid
  );
endinterface

// File: rtl/acc_requant.sv
//------------------------------------------------------------------------------
// acc_requant
// Requantizes the accumulator's final-sum stream. Each of DN lanes is
// multiplied by an unsigned scale, rounding-right-shifted (round half up),
// optionally ReLU-clamped and saturated to a signed OW-bit value. The source
// cannot be stalled, so results land in a DEPTH-beat FIFO and an almost-full
// flag is returned to the scheduler.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, latches size/cfg_* when idle
//   size         : number of beats in the job
//   cfg_scale    : unsigned multiplier
//   cfg_shift    : right-shift amount 0..31
//   cfg_relu     : clamp negative results to zero
//   cfg_zp       : signed zero point (only with ACC_REQUANT_ZP_EN)
//   bus          : s_sum/s_valid in, o_data/o_valid/o_ready out (slave)
//   afull        : FIFO occupancy >= DEPTH-3
//   busy         : job in progress
//   done         : one-cycle pulse at job end
//   ovf_err      : sticky, a beat was dropped because the FIFO was full
//
// Optional feature: define ACC_REQUANT_ZP_EN to add the cfg_zp port; the zero
// point is added after the shift, before ReLU and saturation.
//------------------------------------------------------------------------------
module acc_requant #(
  parameter int DW    = 22,
  parameter int DN    = 6,
  parameter int OW    = 8,
  parameter int MW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [10:0]          size,
  input  logic [MW-1:0]        cfg_scale,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
`ifdef ACC_REQUANT_ZP_EN
  input  logic signed [OW-1:0] cfg_zp,
`endif
  acc_requant_if.slave         bus,
  output logic                 afull,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_err
);

  localparam int PW = DW + MW + 1;   // full signed product width
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [PW-1:0] PW_ONE   = PW'(1);
  localparam logic signed [PW-1:0] SAT_MAX  = PW'((2 ** (OW - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN  = PW'(-(2 ** (OW - 1)));
  localparam logic [OW-1:0]        OUT_MAX  = OW'((2 ** (OW - 1)) - 1);
  localparam logic [OW-1:0]        OUT_MIN  = OW'(2 ** (OW - 1));
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
  // Two beats can be in the pipeline plus one arriving this cycle.
  localparam logic [CW-1:0]        AFULL_TH = CW'(DEPTH - 3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [10:0]            size_r;
  logic [MW-1:0]          scale_r;
  logic [4:0]             shift_r;
  logic                   relu_r;
  logic [10:0]            cnt_r;

  logic                   start_acc_s;
  logic                   beat_acc_s;
  logic                   drain_ok_s;
  logic                   done_s;

  logic                   s1_vld_r;
  logic                   s2_vld_r;
  logic signed [PW-1:0]   prod_s  [DN];
  logic signed [PW-1:0]   p1_r    [DN];
  logic signed [PW-1:0]   rnd_s;
  logic signed [PW-1:0]   shr_s   [DN];
  logic signed [PW-1:0]   r2_r    [DN];
  logic signed [PW-1:0]   zp_ext_s;
  logic signed [PW-1:0]   sum3_s  [DN];
  logic signed [PW-1:0]   clip_s  [DN];
  logic [OW*DN-1:0]       q_s;

  logic [OW*DN-1:0]       mem_r   [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          count_nxt_s;
  logic                   full_s;
  logic                   rd_en_s;
  logic                   wr_en_s;
  logic                   wr_ok_s;
  logic                   drop_s;

  logic                   o_valid_r;
  logic                   afull_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   ovf_r;

`ifdef ACC_REQUANT_ZP_EN
  logic signed [OW-1:0]   zp_r;

  // Zero-point register, latched with the rest of the job configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zp_r <= {OW{1'b0}};
    end else if (start_acc_s) begin
      zp_r <= cfg_zp;
    end else begin
      zp_r <= zp_r;
    end
  end

  assign zp_ext_s = {{(PW-OW){zp_r[OW-1]}}, zp_r};
`else
  assign zp_ext_s = {PW{1'b0}};
`endif

  //----------------------------------------------------------------------------
  // Job control FSM
  //----------------------------------------------------------------------------
  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign beat_acc_s  = (state_r == ST_RUN) && bus.s_valid;
  assign drain_ok_s  = !s1_vld_r && !s2_vld_r && (count_r == {CW{1'b0}});

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (size == 11'd0) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_acc_s && ((cnt_r + 11'd1) == size_r)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_ok_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: done fires as DRAIN finds everything empty.
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      ST_DRAIN: begin
        done_s = drain_ok_s;
      end
      ST_IDLE, ST_RUN: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= done_s;
    end
  end

  // Job configuration and beat counter; config only moves on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_r  <= 11'd0;
      scale_r <= {MW{1'b0}};
      shift_r <= 5'd0;
      relu_r  <= 1'b0;
      cnt_r   <= 11'd0;
    end else if (start_acc_s) begin
      size_r  <= size;
      scale_r <= cfg_scale;
      shift_r <= cfg_shift;
      relu_r  <= cfg_relu;
      cnt_r   <= 11'd0;
    end else if (beat_acc_s) begin
      cnt_r   <= cnt_r + 11'd1;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  //----------------------------------------------------------------------------
  // Requantization datapath
  //----------------------------------------------------------------------------
  // Stage 1: signed lane times zero-extended scale, both widened to PW first.
  always_comb begin
    for (int i = 0; i < DN; i++) begin
      prod_s[i] = $signed({{(MW+1){bus.s_sum[i*DW+DW-1]}}, bus.s_sum[i*DW +: DW]})
                * $signed({{(DW+1){1'b0}}, scale_r});
    end
  end

  // Stage 2: add half an LSB of the result, then arithmetic shift.
  always_comb begin
    if (shift_r == 5'd0) begin
      rnd_s = {PW{1'b0}};
    end else begin
      rnd_s = PW_ONE <<< (shift_r - 5'd1);
    end
    for (int i = 0; i < DN; i++) begin
      shr_s[i] = (p1_r[i] + rnd_s) >>> shift_r;
    end
  end

  // Stage 3: zero point, ReLU and saturation, feeding the FIFO write port.
  always_comb begin
    q_s = {(OW*DN){1'b0}};
    for (int i = 0; i < DN; i++) begin
      sum3_s[i] = r2_r[i] + zp_ext_s;
      if (relu_r && sum3_s[i][PW-1]) begin
        clip_s[i] = {PW{1'b0}};
      end else begin
        clip_s[i] = sum3_s[i];
      end
      if (clip_s[i] > SAT_MAX) begin
        q_s[i*OW +: OW] = OUT_MAX;
      end else if (clip_s[i] < SAT_MIN) begin
        q_s[i*OW +: OW] = OUT_MIN;
      end else begin
        q_s[i*OW +: OW] = clip_s[i][OW-1:0];
      end
    end
  end

  // Pipeline registers for stages 1 and 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
      for (int i = 0; i < DN; i++) begin
        p1_r[i] <= {PW{1'b0}};
        r2_r[i] <= {PW{1'b0}};
      end
    end else begin
      s1_vld_r <= beat_acc_s;
      s2_vld_r <= s1_vld_r;
      for (int i = 0; i < DN; i++) begin
        p1_r[i] <= prod_s[i];
        r2_r[i] <= shr_s[i];
      end
    end
  end

  //----------------------------------------------------------------------------
  // Output FIFO
  //----------------------------------------------------------------------------
  assign full_s  = (count_r == FULL_CNT);
  assign rd_en_s = o_valid_r && bus.o_ready;
  assign wr_en_s = s2_vld_r;
  // On a full FIFO a same-cycle pop frees the slot being written.
  assign wr_ok_s = wr_en_s && (!full_s || rd_en_s);
  assign drop_s  = wr_en_s && full_s && !rd_en_s;

  // Next occupancy, shared by the counter and the registered flags.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and the flags derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem_r[d] <= {(OW*DN){1'b0}};
      end
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      o_valid_r <= 1'b0;
      afull_r   <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= q_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r   <= count_nxt_s;
      o_valid_r <= (count_nxt_s != {CW{1'b0}});
      afull_r   <= (count_nxt_s >= AFULL_TH);
    end
  end

  // Sticky overflow flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (start_acc_s) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Head of the FIFO is presented directly; storage resets to zero.
  assign bus.o_data  = mem_r[rd_ptr_r];
  assign bus.o_valid = o_valid_r;
  assign afull       = afull_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign ovf_err     = ovf_r;

endmodule

// File: tb/tb_acc_requant.sv
//------------------------------------------------------------------------------
// tb_acc_requant
// Directed testbench for acc_requant with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are read at that point
// too, so each read shows the registered state of the current cycle.
//------------------------------------------------------------------------------
module tb_acc_requant;

  localparam int DW    = 22;
  localparam int DN    = 6;
  localparam int OW    = 8;
  localparam int MW    = 16;
  localparam int DEPTH = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          start     = 1'b0;
  logic [10:0]   size      = 11'd0;
  logic [MW-1:0] cfg_scale = {MW{1'b0}};
  logic [4:0]    cfg_shift = 5'd0;
  logic          cfg_relu  = 1'b0;
`ifdef ACC_REQUANT_ZP_EN
  logic signed [OW-1:0] cfg_zp = {OW{1'b0}};
`endif
  logic          afull;
  logic          busy;
  logic          done;
  logic          ovf_err;

  int n_chk = 0;
  int n_err = 0;

  acc_requant_if #(.DW(DW), .DN(DN), .OW(OW)) bus ();

  acc_requant #(
    .DW(DW), .DN(DN), .OW(OW), .MW(MW), .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
`ifdef ACC_REQUANT_ZP_EN
    .cfg_zp    (cfg_zp),
`endif
    .bus       (bus),
    .afull     (afull),
    .busy      (busy),
    .done      (done),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*DN-1:0] pack_sum(input int l0, l1, l2, l3, l4, l5);
    int l [DN];
    logic [DW*DN-1:0] r;
    l = '{l0, l1, l2, l3, l4, l5};
    r = '0;
    for (int i = 0; i < DN; i++) r[i*DW +: DW] = DW'(l[i]);
    return r;
  endfunction

  function automatic logic [OW*DN-1:0] pack_out(input int l0, l1, l2, l3, l4, l5);
    int l [DN];
    logic [OW*DN-1:0] r;
    l = '{l0, l1, l2, l3, l4, l5};
    r = '0;
    for (int i = 0; i < DN; i++) r[i*OW +: OW] = OW'(l[i]);
    return r;
  endfunction

  // Beat t carries lane i = 10*t + i; with scale 1, shift 0 it passes through.
  function automatic logic [DW*DN-1:0] beat_sum(input int t);
    return pack_sum(10*t, 10*t+1, 10*t+2, 10*t+3, 10*t+4, 10*t+5);
  endfunction

  function automatic logic [OW*DN-1:0] beat_out(input int t);
    return pack_out(10*t, 10*t+1, 10*t+2, 10*t+3, 10*t+4, 10*t+5);
  endfunction

  // Pulses start for one cycle; returns in the first RUN/DRAIN cycle.
  task automatic start_job(input logic [10:0] sz, input logic [MW-1:0] sc,
                           input logic [4:0] sh, input logic rl);
    step();
    start = 1'b1; size = sz; cfg_scale = sc; cfg_shift = sh; cfg_relu = rl;
    step();
    start = 1'b0;
  endtask

  // Single-beat job: checks latency 3, data, and done two cycles after the pop.
  task automatic one_beat(input string tag, input logic [MW-1:0] sc, input logic [4:0] sh,
                          input logic rl, input logic [DW*DN-1:0] sum,
                          input logic [OW*DN-1:0] exp);
    int lat;
    int dlat;
    bus.o_ready = 1'b1;
    start_job(11'd1, sc, sh, rl);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    bus.s_valid = 1'b1;
    bus.s_sum   = sum;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      bus.s_valid = 1'b0;
      if (bus.o_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_data"}, 64'(bus.o_data), 64'(exp));
    dlat = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (done) begin
        dlat = k;
        break;
      end
    end
    chk({tag, "_done_lat"}, 64'(dlat), 64'd2);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int occ;
    int n_out;
    bit got_done;

    bus.s_sum   = '0;
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_data", 64'(bus.o_data), 64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1. Basic pass-through
    one_beat("basic", 16'd1, 5'd0, 1'b0, pack_sum(5, 5, 5, 5, 5, 5), pack_out(5, 5, 5, 5, 5, 5));

    // 2. Rounding and saturation
    one_beat("round", 16'd3, 5'd2, 1'b0, pack_sum(10, -10, 1000, -1000, 2, -3),
             pack_out(8, -7, 127, -128, 2, -2));

    // 3. ReLU
    one_beat("relu", 16'd1, 5'd0, 1'b1, pack_sum(-1, 0, 1, -128, 127, 300),
             pack_out(0, 0, 1, 0, 127, 127));

    // 4. Backpressure and overflow: occupancy at cycle N+t+1 is clamp(t-1, 0, 8)
    bus.o_ready = 1'b0;
    start_job(11'd10, 16'd1, 5'd0, 1'b0);
    for (int t = 0; t < 14; t++) begin
      if (t < 10) begin
        bus.s_valid = 1'b1;
        bus.s_sum   = beat_sum(t);
      end else begin
        bus.s_valid = 1'b0;
      end
      step();
      occ = (t < 1) ? 0 : ((t - 1 > DEPTH) ? DEPTH : t - 1);
      chk($sformatf("bp_afull_t%0d", t), 64'(afull), 64'(occ >= DEPTH - 3));
      chk($sformatf("bp_valid_t%0d", t), 64'(bus.o_valid), 64'(occ > 0));
    end
    bus.s_valid = 1'b0;
    chk("bp_ovf", 64'(ovf_err), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    bus.o_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      chk($sformatf("bp_pop_valid%0d", j), 64'(bus.o_valid), 64'd1);
      chk($sformatf("bp_pop_data%0d", j), 64'(bus.o_data), 64'(beat_out(j)));
      step();
    end
    chk("bp_empty", 64'(bus.o_valid), 64'd0);
    got_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("bp_done", 64'(got_done), 64'd1);
    chk("bp_ovf_sticky", 64'(ovf_err), 64'd1);

    // 5a. size == 0: done one cycle after entering DRAIN, start clears ovf_err
    start_job(11'd0, 16'd1, 5'd0, 1'b0);
    chk("sz0_busy", 64'(busy), 64'd1);
    chk("sz0_ovf_clr", 64'(ovf_err), 64'd0);
    chk("sz0_done_early", 64'(done), 64'd0);
    step();
    chk("sz0_done", 64'(done), 64'd1);
    chk("sz0_idle", 64'(busy), 64'd0);

    // 5b. start during RUN ignored; 12 beats with size 10 give exactly 10 outputs
    bus.o_ready = 1'b1;
    start_job(11'd10, 16'd1, 5'd0, 1'b0);
    n_out    = 0;
    got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 12) begin
        bus.s_valid = 1'b1;
        bus.s_sum   = beat_sum(c);
      end else begin
        bus.s_valid = 1'b0;
      end
      start = (c == 3);
      if (c == 3) begin
        size      = 11'd2;
        cfg_scale = 16'd2;
      end
      step();
      start = 1'b0;
      if (bus.o_valid) begin
        if (n_out < 10) chk($sformatf("job_data%0d", n_out), 64'(bus.o_data), 64'(beat_out(n_out)));
        n_out++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    bus.s_valid = 1'b0;
    chk("job_count", 64'(n_out), 64'd10);
    chk("job_done", 64'(got_done), 64'd1);

    // 6. Async reset mid-RUN with three beats held and ovf_err set
    bus.o_ready = 1'b0;
    start_job(11'd20, 16'd1, 5'd0, 1'b0);
    for (int t = 0; t < 11; t++) begin
      bus.s_valid = 1'b1;
      bus.s_sum   = beat_sum(t);
      step();
    end
    bus.s_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("mr_pre_ovf", 64'(ovf_err), 64'd1);
    bus.o_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    bus.o_ready = 1'b0;
    chk("mr_pre_valid", 64'(bus.o_valid), 64'd1);
    chk("mr_pre_head", 64'(bus.o_data), 64'(beat_out(5)));
    chk("mr_pre_afull", 64'(afull), 64'd0);
    chk("mr_pre_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_o_valid", 64'(bus.o_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ovf", 64'(ovf_err), 64'd0);
    chk("mr_o_data", 64'(bus.o_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    one_beat("post_rst", 16'd2, 5'd1, 1'b0, pack_sum(7, -7, 100, -100, 0, 64),
             pack_out(7, -7, 100, -100, 0, 64));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
